// File: rtl/window_pkg.sv
// Shared encodings for the chirp window sequencer and the window it drives.
package window_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  // Strobes between a windowed sample going in and its output coming out.
  localparam int LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ARMED  = ST_ARMED,
    S_SETTLE = ST_SETTLE,
    S_ACTIVE = ST_ACTIVE,
    S_DRAIN  = ST_DRAIN
  } state_t;

endpackage

// File: rtl/window_seq_if.sv
// Sample/control bundle between the receive chain and the window sequencer.
interface window_seq_if #(
  parameter int N      = 1024,
  parameter int SKIP_W = 10,
  parameter int OVR_W  = 8
);
  logic                 run;
  logic                 chirp_start;
  logic                 sample_stb;
  logic [SKIP_W-1:0]    cfg_skip;
  logic                 fft_ready;
  logic                 win_dvalid;
  logic                 win_clk_en;
  logic                 win_en;
  logic                 frame_start;
  logic                 frame_done;
  logic                 busy;
  logic [$clog2(N)-1:0] sample_idx;
  logic [OVR_W-1:0]     overrun_cnt;

  modport master (
    output run, chirp_start, sample_stb, cfg_skip, fft_ready, win_dvalid,
    input  win_clk_en, win_en, frame_start, frame_done, busy, sample_idx, overrun_cnt
  );

  modport slave (
    input  run, chirp_start, sample_stb, cfg_skip, fft_ready, win_dvalid,
    output win_clk_en, win_en, frame_start, frame_done, busy, sample_idx, overrun_cnt
  );
endinterface

// File: rtl/window_seq_sat_counter.sv
// Saturating up-counter; holds at all-ones until cleared or reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;
endmodule

// File: rtl/window_seq.sv
// Per-chirp sequencer: skip settling samples, window exactly N strobes,
// then wait for the N windowed outputs before signalling frame completion.
module window_seq
  import window_pkg::*;
#(
  parameter int N      = 1024,
  parameter int SKIP_W = 10,
  parameter int OVR_W  = 8
) (
  input  logic        clk,
  input  logic        srst,
  window_seq_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int OUT_W = IDX_W + 1;

  state_t            state_q;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic [IDX_W-1:0]  sample_idx_q;
  logic [OUT_W-1:0]  out_cnt_q;
  logic [OUT_W-1:0]  out_cnt_d;
  logic              frame_start_q;
  logic              frame_done_q;
  logic              out_hit;
  logic              ovr_inc;

  assign out_hit   = bus.win_dvalid & bus.sample_stb;
  assign out_cnt_d = out_cnt_q + 1'b1;

  // Any chirp not accepted while the sequencer is enabled counts as an overrun.
  assign ovr_inc = bus.chirp_start &
                   (((state_q == S_ARMED) & bus.run & ~bus.fft_ready) |
                    (state_q inside {S_SETTLE, S_ACTIVE, S_DRAIN}));

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      skip_cnt_q    <= '0;
      sample_idx_q  <= '0;
      out_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (out_hit && (state_q inside {S_ACTIVE, S_DRAIN})) begin
        out_cnt_q <= out_cnt_d;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.run) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (!bus.run) begin
            state_q <= S_IDLE;
          end else if (bus.chirp_start && bus.fft_ready) begin
            skip_cnt_q    <= bus.cfg_skip;
            sample_idx_q  <= '0;
            out_cnt_q     <= '0;
            frame_start_q <= 1'b1;
            state_q       <= (bus.cfg_skip != '0) ? S_SETTLE : S_ACTIVE;
          end
        end
        S_SETTLE: begin
          if (bus.sample_stb) begin
            skip_cnt_q <= skip_cnt_q - 1'b1;
            if (skip_cnt_q == SKIP_W'(1)) state_q <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (bus.sample_stb) begin
            if (sample_idx_q == IDX_W'(N - 1)) begin
              sample_idx_q <= '0;
              state_q      <= S_DRAIN;
            end else begin
              sample_idx_q <= sample_idx_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_hit && (out_cnt_d == OUT_W'(N))) begin
            frame_done_q <= 1'b1;
            state_q      <= bus.run ? S_ARMED : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(OVR_W)) u_ovr (
    .clk   (clk),
    .srst  (srst),
    .inc   (ovr_inc),
    .clr   (1'b0),
    .count (bus.overrun_cnt)
  );

  assign bus.win_clk_en  = bus.sample_stb;
  assign bus.win_en      = (state_q == S_ACTIVE);
  assign bus.busy        = (state_q inside {S_SETTLE, S_ACTIVE, S_DRAIN});
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sample_idx  = sample_idx_q;
endmodule

// File: doc/window_seq.md
Name: window_seq

Overview:
- Per-chirp frame sequencer for the sample-window stage of the FMCW receive chain.
- Waits for a chirp-start pulse and discards a configurable number of settling samples.
- Drives the window's en/clk_en so that exactly N consecutive samples are windowed, then counts the N windowed outputs and signals frame completion.
- Sits between the ADC/decimator sample strobe and the window → FFT path; refuses new chirps while the downstream FFT is not ready, and counts them as overruns.

Parameters:
N, 1024, frame length in samples; must match the window's N; power of two, ≥4.
SKIP_W, 10, width of the settling-skip count input.
OVR_W, 8, width of the saturating overrun counter.

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active-high
run  in  1  sequencing enable
chirp_start  in  1  single-cycle pulse at ramp start
sample_stb  in  1  new ADC sample this cycle
cfg_skip  in  SKIP_W  settling samples to discard; sampled at chirp acceptance
fft_ready  in  1  downstream can accept a full frame
win_dvalid  in  1  window output-valid
win_clk_en  out  1  clock enable to window; equals sample_stb (combinational)
win_en  out  1  window enable; high iff state==ACTIVE
frame_start  out  1  registered pulse, cycle after chirp acceptance
frame_done  out  1  registered pulse when Nth windowed output is seen
busy  out  1  state in SETTLE, ACTIVE or DRAIN
sample_idx  out  log2(N)  index of the next sample to be windowed
overrun_cnt  out  OVR_W  saturating count of rejected chirps

Behaviour:
- Reset (srst high at posedge): state IDLE; all registered outputs 0; overrun_cnt 0; internal counters 0. Reset mid-frame aborts silently, with no frame_done.
- States: IDLE, ARMED, SETTLE, ACTIVE, DRAIN; binary encoded.
- IDLE:
  - run=1 → ARMED.
  - chirp_start is ignored and not counted.
- ARMED:
  - run=0 → IDLE.
  - chirp_start & fft_ready → accept: latch cfg_skip into skip_cnt, clear sample_idx and out_cnt, pulse frame_start next cycle. Go to SETTLE if cfg_skip≠0, else ACTIVE.
  - chirp_start & !fft_ready → overrun_cnt+1 (saturating at all-ones); stay ARMED.
  - A sample_stb coincident with acceptance is not consumed; the first counted strobe is in a later cycle.
- SETTLE: each sample_stb decrements skip_cnt; a strobe with skip_cnt==1 → ACTIVE. win_en stays low.
- ACTIVE:
  - Each sample_stb increments sample_idx.
  - A strobe with sample_idx==N-1 wraps sample_idx to 0 → DRAIN.
  - win_en is high for exactly N strobe cycles per frame; the window sees en=1 on precisely those N clk_en cycles.
- Output counting, in ACTIVE and DRAIN: out_cnt increments on each cycle with win_dvalid & sample_stb. In IDLE, ARMED and SETTLE, out_cnt neither increments nor is compared.
- DRAIN:
  - When the increment takes out_cnt to N: pulse frame_done next cycle, then go to ARMED if run=1, else IDLE.
  - Window latency is 2 strobes, so DRAIN normally lasts 2 strobes.
- chirp_start during SETTLE, ACTIVE or DRAIN → overrun_cnt+1 (saturating); the frame in progress is unaffected.
- run deassert during SETTLE, ACTIVE or DRAIN: the frame completes normally; the FSM returns to IDLE after DRAIN.
- Simultaneous chirp_start and the frame_done transition: the chirp counts as an overrun, since the state is not ARMED that cycle.
- sample_stb may be any duty cycle, including continuous (every clk).

Decomposition:
- Shared package window_pkg: state encoding localparams (ST_IDLE..ST_DRAIN) and the window LATENCY constant (2); the window module reuses both.
- One natural sub-module: sat_counter (parameter WIDTH; inc, clr, count), used for overrun_cnt.
- Everything else lives in a single FSM always block.

Test Plan (bench N=16, stub window model with 2-strobe dvalid delay):
1. Nominal: run=1, fft_ready=1, cfg_skip=3, chirp_start, then continuous sample_stb → strobes 1–3 win_en=0; strobes 4–19 win_en=1 (16 cycles); frame_done 2 strobes after the last en strobe; state back to ARMED; overrun_cnt=0.
2. Sparse strobes: sample_stb every 4th clk, cfg_skip=0 → win_en high across 16 strobes (~64 clks); sample_idx 0..15 then 0; exactly one frame_done.
3. Backpressure: fft_ready=0, three chirp_start pulses in ARMED → overrun_cnt=3, no frame_start. Then fft_ready=1 and one pulse → frame_start.
4. Chirp mid-frame: chirp_start during ACTIVE at idx 7 → overrun_cnt+1; frame completes with 16 en strobes.
5. Saturation: OVR_W=2 with 5 rejected chirps → overrun_cnt=3 and holds.
6. Reset mid-ACTIVE at idx 5 → next cycle: state IDLE, win_en=0, busy=0, overrun_cnt=0, no frame_done. With run still high, the block re-arms and runs a subsequent frame normally.
